// File: rtl/swd_phy_xfer.sv
// swd_phy_xfer: SWD host PHY executing one complete SWD transfer per request.
//   Header, turnaround, ACK, data/parity and trailing idle bits, with automatic
//   WAIT retry. SWDCLK is derived from CLK by a programmable divider.
// Ports:
//   CLK, RESETn            core clock, synchronous active-low reset
//   DIV, TURN, RETRIES     divider, turnaround length-1, max WAIT retries (sampled at accept)
//   VALID/READY            request handshake; APNDP, RNW, ADDR, WDATA request fields
//   RVALID, RDATA, ERR     completion pulse, read data and status
//   SWDCLK, SWDIN, SWDOUT, SWDOE   SWD pins
module swd_phy_xfer #(
   parameter int unsigned DIV_W     = 8,
   parameter int unsigned RETRY_W   = 4,
   parameter int unsigned IDLE_BITS = 2
) (
   input  logic               CLK,
   input  logic               RESETn,
   input  logic [DIV_W-1:0]   DIV,
   input  logic [1:0]         TURN,
   input  logic [RETRY_W-1:0] RETRIES,
   input  logic               VALID,
   output logic               READY,
   input  logic               APNDP,
   input  logic               RNW,
   input  logic [1:0]         ADDR,
   input  logic [31:0]        WDATA,
   output logic               RVALID,
   output logic [31:0]        RDATA,
   output logic [2:0]         ERR,
   output logic               SWDCLK,
   input  logic               SWDIN,
   output logic               SWDOUT,
   output logic               SWDOE
);

   localparam int unsigned BIT_W = 6;
   localparam logic [2:0] ACK_OK    = 3'b001;
   localparam logic [2:0] ACK_WAIT  = 3'b010;
   localparam logic [2:0] ACK_FAULT = 3'b100;
   localparam logic [2:0] ACK_NONE  = 3'b111;

   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_TRN1, S_ACK, S_RDATA, S_TRN3, S_TRN2, S_WDATA, S_IDLEB
   } state_t;

   typedef struct packed {
      logic               apndp;
      logic               rnw;
      logic [1:0]         addr;
      logic [31:0]        wdata;
      logic [DIV_W-1:0]   div;
      logic [1:0]         turn;
      logic [RETRY_W-1:0] retries;
   } req_t;

   state_t             state_q, state_d;
   req_t               req_q, req_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic               phase_q, phase_d;
   logic [BIT_W-1:0]   bit_q, bit_d, last_m;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [2:0]         ack_q, ack_d;
   logic [31:0]        rsh_q, rsh_d;
   logic               rpar_q, rpar_d;
   logic               ready_d, rvalid_d, swdclk_d, swdout_d, swdoe_d;
   logic [31:0]        rdata_d;
   logic [2:0]         err_d;

   // Pin values {oe, out} at the start of bit b of state s.
   function automatic logic [1:0] drive_bit(input state_t s, input logic [BIT_W-1:0] b,
                                            input req_t r);
      logic [7:0] hdr;
      logic [1:0] d;
      hdr = {1'b1, 1'b0, r.apndp ^ r.rnw ^ r.addr[0] ^ r.addr[1],
             r.addr[1], r.addr[0], r.rnw, r.apndp, 1'b1};
      d = 2'b00;
      case (s)
         S_IDLE, S_IDLEB: d = 2'b10;
         S_HDR:           d = {1'b1, hdr[b[2:0]]};
         S_WDATA:         d = {1'b1, b[5] ? ^r.wdata : r.wdata[b[4:0]]};
         default:         d = 2'b00;
      endcase
      return d;
   endfunction

   // Next-state, bit timing and output logic.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      div_cnt_d = div_cnt_q;
      phase_d   = phase_q;
      bit_d     = bit_q;
      retry_d   = retry_q;
      ack_d     = ack_q;
      rsh_d     = rsh_q;
      rpar_d    = rpar_q;
      ready_d   = READY;
      rvalid_d  = 1'b0;
      rdata_d   = RDATA;
      err_d     = ERR;
      swdclk_d  = SWDCLK;
      swdout_d  = SWDOUT;
      swdoe_d   = SWDOE;
      last_m    = '0;

      case (state_q)
         S_HDR:                  last_m = BIT_W'(7);
         S_TRN1, S_TRN2, S_TRN3: last_m = BIT_W'(req_q.turn);
         S_ACK:                  last_m = BIT_W'(2);
         S_RDATA, S_WDATA:       last_m = BIT_W'(32);
         S_IDLEB:                last_m = BIT_W'(IDLE_BITS - 1);
         default:                last_m = '0;
      endcase

      if (state_q == S_IDLE) begin
         if (VALID && READY) begin
            req_d.apndp   = APNDP;
            req_d.rnw     = RNW;
            req_d.addr    = ADDR;
            req_d.wdata   = WDATA;
            req_d.div     = DIV;
            req_d.turn    = TURN;
            req_d.retries = RETRIES;
            retry_d       = '0;
            div_cnt_d     = '0;
            phase_d       = 1'b0;
            bit_d         = '0;
            err_d         = '0;
            ready_d       = 1'b0;
            state_d       = S_HDR;
            {swdoe_d, swdout_d} = drive_bit(S_HDR, '0, req_d);
         end
      end else if (div_cnt_q != req_q.div) begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end else if (!phase_q) begin
         // Rising SWDCLK: sample target data (shifted in LSB first).
         div_cnt_d = '0;
         phase_d   = 1'b1;
         swdclk_d  = 1'b1;
         if (state_q == S_ACK) begin
            ack_d = {SWDIN, ack_q[2:1]};
         end else if (state_q == S_RDATA) begin
            if (bit_q[5]) rpar_d = SWDIN;
            else          rsh_d  = {SWDIN, rsh_q[31:1]};
         end
      end else begin
         // Falling SWDCLK: end of bit, advance and drive the next bit.
         div_cnt_d = '0;
         phase_d   = 1'b0;
         swdclk_d  = 1'b0;
         if (bit_q != last_m) begin
            bit_d = bit_q + BIT_W'(1);
         end else begin
            bit_d = '0;
            case (state_q)
               S_HDR:  state_d = S_TRN1;
               S_TRN1: state_d = S_ACK;
               S_ACK:  state_d = (ack_q == ACK_OK && req_q.rnw) ? S_RDATA : S_TRN2;
               S_RDATA: begin
                  state_d = S_TRN3;
                  rdata_d = rsh_q;
                  if (rpar_q != ^rsh_q) err_d = 3'd4;
               end
               S_TRN3: state_d = S_IDLEB;
               S_TRN2: begin
                  state_d = S_IDLEB;
                  case (ack_q)
                     ACK_OK:    state_d = S_WDATA;
                     ACK_WAIT: begin
                        if (retry_q < req_q.retries) begin
                           retry_d = retry_q + RETRY_W'(1);
                           state_d = S_HDR;
                        end else begin
                           err_d = 3'd2;
                        end
                     end
                     ACK_FAULT: err_d = 3'd1;
                     ACK_NONE:  err_d = 3'd3;
                     default:   err_d = 3'd7;
                  endcase
               end
               S_WDATA: state_d = S_IDLEB;
               S_IDLEB: begin
                  state_d  = S_IDLE;
                  ready_d  = 1'b1;
                  rvalid_d = 1'b1;
               end
               default: state_d = S_IDLE;
            endcase
         end
         {swdoe_d, swdout_d} = drive_bit(state_d, bit_d, req_q);
      end
   end

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         state_q   <= S_IDLE;
         req_q     <= '0;
         div_cnt_q <= '0;
         phase_q   <= 1'b0;
         bit_q     <= '0;
         retry_q   <= '0;
         ack_q     <= '0;
         rsh_q     <= '0;
         rpar_q    <= 1'b0;
         READY     <= 1'b1;
         RVALID    <= 1'b0;
         RDATA     <= '0;
         ERR       <= '0;
         SWDCLK    <= 1'b0;
         SWDOUT    <= 1'b0;
         SWDOE     <= 1'b1;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         div_cnt_q <= div_cnt_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         retry_q   <= retry_d;
         ack_q     <= ack_d;
         rsh_q     <= rsh_d;
         rpar_q    <= rpar_d;
         READY     <= ready_d;
         RVALID    <= rvalid_d;
         RDATA     <= rdata_d;
         ERR       <= err_d;
         SWDCLK    <= swdclk_d;
         SWDOUT    <= swdout_d;
         SWDOE     <= swdoe_d;
      end
   end

endmodule

// File: tb/tb_swd_phy_xfer.sv
// tb_swd_phy_xfer: self-checking bench for swd_phy_xfer. A transaction-level
// target model builds the expected per-bit pin stream and the SWDIN response.
module tb_swd_phy_xfer;

   localparam int IDLE_B = 2;

   logic        CLK = 1'b0;
   logic        RESETn = 1'b0;
   logic [7:0]  DIV = '0;
   logic [1:0]  TURN = '0;
   logic [3:0]  RETRIES = '0;
   logic        VALID = 1'b0;
   logic        READY;
   logic        APNDP = 1'b0;
   logic        RNW = 1'b0;
   logic [1:0]  ADDR = '0;
   logic [31:0] WDATA = '0;
   logic        RVALID;
   logic [31:0] RDATA;
   logic [2:0]  ERR;
   logic        SWDCLK;
   logic        SWDIN = 1'b0;
   logic        SWDOUT;
   logic        SWDOE;

   swd_phy_xfer #(.DIV_W(8), .RETRY_W(4), .IDLE_BITS(IDLE_B)) dut (
      .CLK(CLK), .RESETn(RESETn), .DIV(DIV), .TURN(TURN), .RETRIES(RETRIES),
      .VALID(VALID), .READY(READY), .APNDP(APNDP), .RNW(RNW), .ADDR(ADDR),
      .WDATA(WDATA), .RVALID(RVALID), .RDATA(RDATA), .ERR(ERR),
      .SWDCLK(SWDCLK), .SWDIN(SWDIN), .SWDOUT(SWDOUT), .SWDOE(SWDOE)
   );

   always #5 CLK = ~CLK;

   int          n_pass = 0;
   int          n_total = 0;
   bit          exp_oe[$];
   bit          exp_out[$];
   bit          exp_din[$];
   logic [2:0]  ack_seq[$];
   logic [2:0]  exp_err;
   logic [31:0] rdata_hold = '0;
   logic [7:0]  hdr_seen;

   task automatic push(input bit oe, input bit out, input bit din);
      exp_oe.push_back(oe);
      exp_out.push_back(out);
      exp_din.push_back(din);
   endtask

   // Reference model: expected bit sequence, ERR and RDATA for one request.
   task automatic build(input logic apndp, input logic rnw, input logic [1:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input logic [1:0] turn, input logic [3:0] retries,
                        input logic corrupt);
      logic [7:0] hdr;
      logic [2:0] a;
      int retry = 0;
      int ai = 0;
      bit done = 0;
      hdr = {1'b1, 1'b0, apndp ^ rnw ^ addr[0] ^ addr[1], addr[1], addr[0], rnw, apndp, 1'b1};
      exp_oe.delete(); exp_out.delete(); exp_din.delete();
      while (!done) begin
         for (int i = 0; i < 8; i++) push(1, hdr[i], 0);
         for (int i = 0; i <= int'(turn); i++) push(0, 0, 0);
         a = (ai < ack_seq.size()) ? ack_seq[ai] : 3'b001;
         ai++;
         for (int i = 0; i < 3; i++) push(0, 0, a[i]);
         if (a == 3'b001 && rnw) begin
            for (int i = 0; i < 32; i++) push(0, 0, rd[i]);
            push(0, 0, (^rd) ^ corrupt);
            for (int i = 0; i <= int'(turn); i++) push(0, 0, 0);
            exp_err = corrupt ? 3'd4 : 3'd0;
            rdata_hold = rd;
            done = 1;
         end else begin
            for (int i = 0; i <= int'(turn); i++) push(0, 0, 0);
            if (a == 3'b001) begin
               for (int i = 0; i < 32; i++) push(1, wd[i], 0);
               push(1, ^wd, 0);
               exp_err = 3'd0;
               done = 1;
            end else if (a == 3'b010) begin
               if (retry < int'(retries)) retry++;
               else begin exp_err = 3'd2; done = 1; end
            end else begin
               exp_err = (a == 3'b100) ? 3'd1 : (a == 3'b111) ? 3'd3 : 3'd7;
               done = 1;
            end
         end
      end
      for (int i = 0; i < IDLE_B; i++) push(1, 0, 0);
   endtask

   // One transfer: accept, per-cycle pin stream check, completion check.
   // abort_at >= 0 asserts RESETn at the start of that bit instead of completing.
   task automatic run_xfer(input string name, input logic apndp, input logic rnw,
                           input logic [1:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                           input logic [7:0] div, input logic [1:0] turn,
                           input logic [3:0] retries, input logic corrupt, input int abort_at);
      int p, nb, bad_k, bad_c;
      logic [4:0] got, want, bad_got, bad_want;
      bit aborted = 0;
      build(apndp, rnw, addr, wd, rd, turn, retries, corrupt);
      APNDP = apndp; RNW = rnw; ADDR = addr; WDATA = wd;
      DIV = div; TURN = turn; RETRIES = retries; VALID = 1'b1;
      n_total++;
      if (READY !== 1'b1) $display("FAIL %s accept: READY=%b required 1", name, READY);
      else n_pass++;
      @(posedge CLK); #1;
      VALID = 1'b0;
      DIV = 8'($urandom); TURN = 2'($urandom); RETRIES = 4'($urandom);
      WDATA = $urandom; APNDP = 1'($urandom); RNW = 1'($urandom); ADDR = 2'($urandom);
      p = int'(div) + 1;
      nb = exp_oe.size();
      bad_k = -1; bad_c = 0; bad_got = '0; bad_want = '0;
      hdr_seen = '0;
      for (int k = 0; k < nb && !aborted; k++) begin
         for (int c = 0; c < 2 * p && !aborted; c++) begin
            @(negedge CLK);
            if (k == abort_at) begin
               RESETn = 1'b0;
               aborted = 1;
            end else begin
               if (c == 0) begin
                  SWDIN = exp_din[k];
                  if (k < 8) hdr_seen[k] = SWDOUT;
               end
               got  = {SWDCLK, SWDOE, SWDOUT, RVALID, READY};
               want = {(c >= p), exp_oe[k], exp_out[k], 1'b0, 1'b0};
               if (got !== want && bad_k < 0) begin
                  bad_k = k; bad_c = c; bad_got = got; bad_want = want;
               end
            end
         end
      end
      n_total++;
      if (bad_k >= 0)
         $display("FAIL %s stream: bit %0d cycle %0d {clk,oe,out,rvalid,ready}=%b required %b",
                  name, bad_k, bad_c, bad_got, bad_want);
      else n_pass++;
      if (aborted) begin
         @(negedge CLK);
         rdata_hold = '0;
         n_total++;
         if ({READY, RVALID, SWDCLK, SWDOE, SWDOUT} !== 5'b10010 || RDATA !== 32'h0)
            $display("FAIL %s reset: {ready,rvalid,clk,oe,out}=%b RDATA=%h required 10010 0",
                     name, {READY, RVALID, SWDCLK, SWDOE, SWDOUT}, RDATA);
         else n_pass++;
         return;
      end
      @(negedge CLK);
      n_total++;
      if ({RVALID, READY} !== 2'b11)
         $display("FAIL %s done: {rvalid,ready}=%b required 11", name, {RVALID, READY});
      else n_pass++;
      n_total++;
      if (ERR !== exp_err) $display("FAIL %s err: ERR=%0d required %0d", name, ERR, exp_err);
      else n_pass++;
      n_total++;
      if (RDATA !== rdata_hold)
         $display("FAIL %s rdata: RDATA=%h required %h", name, RDATA, rdata_hold);
      else n_pass++;
      n_total++;
      if ({SWDCLK, SWDOE, SWDOUT} !== 3'b010)
         $display("FAIL %s idle pins: {clk,oe,out}=%b required 010", name, {SWDCLK, SWDOE, SWDOUT});
      else n_pass++;
   endtask

   task automatic test_reset();
      RESETn = 1'b0;
      repeat (3) @(negedge CLK);
      n_total++;
      if ({READY, RVALID, SWDCLK, SWDOE, SWDOUT} !== 5'b10010)
         $display("FAIL reset pins: {ready,rvalid,clk,oe,out}=%b required 10010",
                  {READY, RVALID, SWDCLK, SWDOE, SWDOUT});
      else n_pass++;
      n_total++;
      if (RDATA !== 32'h0 || ERR !== 3'd0)
         $display("FAIL reset data: RDATA=%h ERR=%0d required 0 0", RDATA, ERR);
      else n_pass++;
      rdata_hold = '0;
      RESETn = 1'b1;
   endtask

   task automatic test_dp_read();
      ack_seq = '{3'b001};
      run_xfer("dp_read", 1'b0, 1'b1, 2'd0, 32'h0, 32'h2BA01477, 8'd0, 2'd0, 4'd0, 1'b0, -1);
      n_total++;
      if (hdr_seen !== 8'hA5) $display("FAIL dp_read hdr: got %h required a5", hdr_seen);
      else n_pass++;
   endtask

   task automatic test_ap_write();
      ack_seq = '{3'b001};
      run_xfer("ap_write", 1'b1, 1'b0, 2'd1, 32'hDEADBEEF, 32'h0, 8'd3, 2'd0, 4'd0, 1'b0, -1);
      n_total++;
      if (hdr_seen !== 8'h8B) $display("FAIL ap_write hdr: got %h required 8b", hdr_seen);
      else n_pass++;
   endtask

   task automatic test_wait_retry();
      ack_seq = '{3'b010, 3'b010, 3'b001};
      run_xfer("wait_ok", 1'b0, 1'b1, 2'd2, 32'h0, 32'hCAFE0001, 8'd1, 2'd0, 4'd2, 1'b0, -1);
      ack_seq = '{3'b010, 3'b010, 3'b001};
      run_xfer("wait_exh", 1'b1, 1'b0, 2'd3, 32'h13572468, 32'h0, 8'd0, 2'd0, 4'd1, 1'b0, -1);
   endtask

   task automatic test_fault();
      ack_seq = '{3'b100};
      run_xfer("fault", 1'b1, 1'b1, 2'd0, 32'h0, 32'h11111111, 8'd0, 2'd1, 4'd3, 1'b0, -1);
      ack_seq = '{3'b111};
      run_xfer("no_ack", 1'b0, 1'b0, 2'd2, 32'h5A5A5A5A, 32'h0, 8'd2, 2'd0, 4'd0, 1'b0, -1);
      ack_seq = '{3'b011};
      run_xfer("bad_ack", 1'b0, 1'b1, 2'd1, 32'h0, 32'h22222222, 8'd0, 2'd0, 4'd0, 1'b0, -1);
   endtask

   task automatic test_parity();
      ack_seq = '{3'b001};
      run_xfer("par_err", 1'b1, 1'b1, 2'd3, 32'h0, 32'h80000001, 8'd0, 2'd0, 4'd0, 1'b1, -1);
      ack_seq = '{3'b001};
      run_xfer("turn3", 1'b1, 1'b1, 2'd2, 32'h0, 32'h0F0F1234, 8'd1, 2'd3, 4'd0, 1'b1, -1);
   endtask

   task automatic test_reset_mid();
      int rv = 0;
      ack_seq = '{3'b001};
      run_xfer("rst_mid", 1'b0, 1'b1, 2'd0, 32'h0, 32'h12345678, 8'd0, 2'd0, 4'd0, 1'b0, 22);
      @(negedge CLK);
      RESETn = 1'b1;
      for (int i = 0; i < 150; i++) begin
         @(negedge CLK);
         if (RVALID === 1'b1) rv++;
      end
      n_total++;
      if (rv != 0) $display("FAIL rst_mid rvalid: %0d pulses required 0", rv);
      else n_pass++;
      ack_seq = '{3'b001};
      run_xfer("post_rst", 1'b0, 1'b1, 2'd0, 32'h0, 32'h2BA01477, 8'd0, 2'd0, 4'd0, 1'b0, -1);
   endtask

   task automatic test_back_to_back();
      ack_seq = '{3'b001};
      run_xfer("b2b_wr", 1'b1, 1'b0, 2'd0, 32'h0000FFFF, 32'h0, 8'd0, 2'd0, 4'd0, 1'b0, -1);
      ack_seq = '{3'b001};
      run_xfer("b2b_rd", 1'b1, 1'b1, 2'd3, 32'h0, 32'hA5A5F00D, 8'd0, 2'd0, 4'd0, 1'b0, -1);
   endtask

   task automatic test_random();
      logic [3:0] ret;
      int nw, r;
      for (int t = 0; t < 20; t++) begin
         ret = 4'($urandom_range(0, 3));
         ack_seq.delete();
         nw = $urandom_range(0, int'(ret) + 1);
         for (int i = 0; i < nw; i++) ack_seq.push_back(3'b010);
         r = $urandom_range(0, 7);
         if (r < 4)       ack_seq.push_back(3'b001);
         else if (r == 4) ack_seq.push_back(3'b100);
         else if (r == 5) ack_seq.push_back(3'b111);
         else             ack_seq.push_back(3'($urandom));
         run_xfer("random", 1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom,
                  8'($urandom_range(0, 3)), 2'($urandom), ret, 1'($urandom_range(0, 3) == 0), -1);
      end
   endtask

   initial begin
      test_reset();
      test_dp_read();
      test_ap_write();
      test_wait_retry();
      test_fault();
      test_parity();
      test_reset_mid();
      test_back_to_back();
      test_random();
      repeat (4) @(negedge CLK);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/swd_phy_xfer.md
Name: swd_phy_xfer

Overview:
- Parameterised SWD host PHY. Executes one complete SWD transfer per request: header, turnaround, ACK, data and parity.
- Generates its own SWDCLK from CLK through a programmable divider. The external clock input and its synchroniser are removed.
- Builds the header and parity internally, checks read-data parity, and retries WAIT responses automatically.
- Sits between the remote-bridge AHB3-lite command sequencer (request/response handshake) and the SWD pins.

Parameters:
DIV_W, 8, width of DIV port; half-period of SWDCLK = DIV+1 CLK cycles
RETRY_W, 4, width of RETRIES port and internal retry counter
IDLE_BITS, 2, trailing idle bits (SWDOUT=0, SWDOE=1) clocked after every transfer

Ports:
CLK  in  1  core clock
RESETn  in  1  synchronous active-low reset
DIV  in  DIV_W  clock divider, sampled at request accept
TURN  in  2  turnaround length = TURN+1 bits, sampled at accept
RETRIES  in  RETRY_W  max WAIT retries, sampled at accept
VALID  in  1  request valid
READY  out  1  engine idle; request accepted on VALID&&READY
APNDP  in  1  0=DP, 1=AP
RNW  in  1  1=read, 0=write
ADDR  in  2  A[3:2]
WDATA  in  32  write data, captured at accept
RVALID  out  1  one-cycle completion pulse
RDATA  out  32  read data, valid with RVALID
ERR  out  3  status, valid with RVALID
SWDCLK  out  1  SWD clock
SWDIN  in  1  SWDIO input
SWDOUT  out  1  SWDIO output value
SWDOE  out  1  SWDIO output enable (1=host drives)

Behaviour:
- Reset values: READY=1, RVALID=0, RDATA=0, ERR=0, SWDCLK=0, SWDOUT=0, SWDOE=1. State=IDLE; divider and retry counters=0.
- Reset mid-transfer aborts the transfer. Outputs return to reset values at the next edge. No RVALID is issued.
- Accept: on VALID&&READY, capture all inputs and drop READY. The first bit starts on the next cycle. VALID while READY=0 is ignored.
- Bit timing: each bit lasts 2*(DIV+1) CLK cycles, with a low phase then a high phase.
  - SWDOUT and SWDOE update at bit start (low phase).
  - SWDIN is sampled on the CLK edge at which SWDCLK goes 0->1.
  - SWDCLK stays 0 in IDLE.
- Header (LSB first): 1, APNDP, RNW, ADDR[0], ADDR[1], P, 0, 1, where P = APNDP^RNW^ADDR[0]^ADDR[1].
- States: IDLE -> HDR(8) -> TRN1(TURN+1) -> ACK(3) -> branch.
  - ACK is assembled LSB-first into ack[2:0].
  - ack=001 (OK) and read: RDATA(33) -> TRN3(TURN+1) -> IDLEB.
  - ack=001 (OK) and write: TRN2(TURN+1) -> WDATA(33) -> IDLEB.
  - ack=010 (WAIT): TRN2. Then, if retry count < RETRIES, increment the count and return to HDR with identical header/data. Otherwise go to IDLEB with ERR=2.
  - ack=100: TRN2 -> IDLEB, ERR=1.
  - ack=111: TRN2 -> IDLEB, ERR=3.
  - Any other ack: TRN2 -> IDLEB, ERR=7.
- SWDOE per state:
  - SWDOE=1 in HDR, WDATA and IDLEB.
  - SWDOE=0 in TRN1, ACK, RDATA and TRN3.
  - TRN2 drives SWDOE=0.
  - SWDOUT=0 whenever SWDOE=0 and in IDLEB.
- Write data: WDATA[0] first, 32 bits, then parity bit ^WDATA.
- Read data: 32 bits LSB first into RDATA, then parity bit. Parity mismatch gives ERR=4; RDATA is still updated.
- Completion: IDLEB lasts IDLE_BITS bits. On the CLK edge ending the last high phase:
  - SWDCLK goes to 0.
  - RVALID=1 for one cycle, with ERR/RDATA valid.
  - READY=1 in the same cycle, so a new accept is possible that same cycle.
- Success: ERR=0. RDATA holds its previous value on writes and on non-OK reads.
- Bit counts, OK transfer, TURN=0, IDLE_BITS=2: read = 8+1+3+33+1+2 = 48 bits; write = 8+1+3+1+33+2 = 48 bits. RVALID occurs 48*2*(DIV+1) CLK cycles after the accept edge.
- DIV=0 is legal (bit period = 2 CLK). DIV, TURN and RETRIES changes during a transfer have no effect.
- The retry counter clears at accept.

Test Plan:
1. DP read DPIDR: APNDP=0, RNW=1, ADDR=0, DIV=0, TURN=0. Model returns ACK=OK and 0x2BA01477 with correct parity. Required: header bits 0xA5 LSB-first, RDATA=0x2BA01477, ERR=0, RVALID 96 CLK after accept.
2. AP write: APNDP=1, RNW=0, ADDR=1, WDATA=0xDEADBEEF, DIV=3. Required: header 0x8B, then 32 data bits plus parity bit 0 (^0xDEADBEEF=0), SWDOE=0 exactly in TRN1/ACK/TRN2, ERR=0, bit period 8 CLK.
3. WAIT retry: RETRIES=2, model answers WAIT, WAIT, OK. Required: 3 headers issued and ERR=0. Repeat with RETRIES=1: ERR=2 after 2 headers and no data phase.
4. FAULT (ack=100) returns ERR=1; SWDIN held high (ack=111) returns ERR=3. In both cases no data phase and SWDOE=1 after TRN2.
5. Read with corrupted parity bit: ERR=4, RDATA still equals the shifted value. Repeat with TURN=3: 4-bit turnarounds observed.
6. RESETn asserted during RDATA bit 10: next edge READY=1, SWDCLK=0, SWDOE=1, no RVALID. A new request accepted after reset completes normally.
